// File: rtl/dcache_load_align_pkg.sv
// Shared load-path definitions: LoadType encoding and the tracking-FIFO entry layout.
package dcache_load_align_pkg;

  localparam logic [1:0] LOADTYPE_LW = 2'b00;
  localparam logic [1:0] LOADTYPE_LH = 2'b01;
  localparam logic [1:0] LOADTYPE_LB = 2'b10;

  typedef struct packed {
    logic       ReadMem;
    logic [1:0] size;
    logic       sign;
  } LoadType;

  // One outstanding load; the discard flag lives in its own resettable register array.
  typedef struct packed {
    logic [1:0] addrLo;
    logic [1:0] size;
    logic       sign;
    logic [4:0] dest;
  } LoadEntry;

endpackage

// File: rtl/dcache_load_align_load_ext.sv
// Combinational load extractor: selects byte/halfword from the returned word and extends it.
module dcache_load_align_load_ext
  import dcache_load_align_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addrLo,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] result
);

  logic [15:0] halfSel;
  logic [7:0]  byteSel;

  always_comb begin
    halfSel = addrLo[1] ? rdata[31:16] : rdata[15:0];
    byteSel = rdata[7:0];
    case (addrLo)
      2'b00:   byteSel = rdata[7:0];
      2'b01:   byteSel = rdata[15:8];
      2'b10:   byteSel = rdata[23:16];
      default: byteSel = rdata[31:24];
    endcase
  end

  always_comb begin
    result = 32'h0;
    case (size)
      LOADTYPE_LW: result = rdata;
      LOADTYPE_LH: result = {{16{sign & halfSel[15]}}, halfSel};
      LOADTYPE_LB: result = {{24{sign & byteSel[7]}}, byteSel};
      default:     result = 32'h0;
    endcase
  end

endmodule

// File: rtl/dcache_load_align.sv
// Load-return alignment: in-order tracking FIFO of issued loads, extraction on DCache return,
// registered writeback result, and flush that discards in-flight loads without reordering.
module dcache_load_align
  import dcache_load_align_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_addr_lo,
  input  logic [1:0]       req_size,
  input  logic             req_sign,
  input  logic [4:0]       req_dest,
  input  logic             rdata_ok,
  input  logic [31:0]      rdata,
  input  logic             flush,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic [4:0]       out_dest,
  output logic [PTR_W:0]   pending_cnt,
  output logic             proto_err
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W:0]   countReg;
  logic [PTR_W-1:0] wptrReg;
  logic [PTR_W-1:0] rptrReg;
  LoadEntry         entryMem [DEPTH];
  logic [DEPTH-1:0] discardReg;

  logic        pushEn;
  logic        popEn;
  LoadEntry    rdEntry;
  logic        rdDiscard;
  logic [31:0] extResult;

  assign req_ready   = (countReg != FULL_CNT);
  assign pushEn      = req_valid && req_ready;
  assign popEn       = rdata_ok && (countReg != '0);
  assign pending_cnt = countReg;
  assign rdEntry     = entryMem[rptrReg];
  assign rdDiscard   = discardReg[rptrReg];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      countReg <= '0;
      wptrReg  <= '0;
      rptrReg  <= '0;
    end else begin
      if (pushEn) wptrReg <= wptrReg + PTR_ONE;
      if (popEn)  rptrReg <= rptrReg + PTR_ONE;
      case ({pushEn, popEn})
        2'b10:   countReg <= countReg + CNT_ONE;
        2'b01:   countReg <= countReg - CNT_ONE;
        default: countReg <= countReg;
      endcase
    end
  end

  // Payload needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      entryMem[wptrReg] <= '{addrLo: req_addr_lo, size: req_size,
                             sign: req_sign, dest: req_dest};
    end
  end

  // A push in the flush cycle lands with discard=1 since it takes the flush value.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_discard
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        discardReg[gi] <= 1'b0;
      end else if (pushEn && (wptrReg == PTR_W'(gi))) begin
        discardReg[gi] <= flush;
      end else if (flush) begin
        discardReg[gi] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      proto_err <= 1'b0;
    end else if (rdata_ok && (countReg == '0)) begin
      proto_err <= 1'b1;
    end
  end

  dcache_load_align_load_ext u_loadExt (
    .rdata  (rdata),
    .addrLo (rdEntry.addrLo),
    .size   (rdEntry.size),
    .sign   (rdEntry.sign),
    .result (extResult)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= 32'h0;
      out_dest  <= 5'h0;
    end else begin
      out_valid <= popEn && !rdDiscard && !flush;
      if (popEn) begin
        out_data <= extResult;
        out_dest <= rdEntry.dest;
      end
    end
  end

endmodule

// File: tb/tb_dcache_load_align.sv
// Scoreboard bench for dcache_load_align: a reference FIFO model predicts results, a monitor compares.
module tb_dcache_load_align;

  localparam int DEPTH = 2;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk;
  logic             resetn;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_addr_lo;
  logic [1:0]       req_size;
  logic             req_sign;
  logic [4:0]       req_dest;
  logic             rdata_ok;
  logic [31:0]      rdata;
  logic             flush;
  logic             out_valid;
  logic [31:0]      out_data;
  logic [4:0]       out_dest;
  logic [PTR_W:0]   pending_cnt;
  logic             proto_err;

  typedef struct {
    logic [1:0] addrLo;
    logic [1:0] size;
    logic       sign;
    logic [4:0] dest;
    logic       discard;
  } ModelEntry;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  dest;
  } ExpResult;

  ModelEntry modelQ[$];
  ExpResult  expQ[$];
  int checks = 0;
  int errors = 0;
  int outValidCount = 0;

  dcache_load_align #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr_lo (req_addr_lo),
    .req_size    (req_size),
    .req_sign    (req_sign),
    .req_dest    (req_dest),
    .rdata_ok    (rdata_ok),
    .rdata       (rdata),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_dest    (out_dest),
    .pending_cnt (pending_cnt),
    .proto_err   (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] refExt(logic [31:0] rd, logic [1:0] a, logic [1:0] sz, logic s);
    logic [31:0] sh;
    logic [31:0] r;
    r = 32'h0;
    case (sz)
      2'd0: r = rd;
      2'd1: begin
        sh = a[1] ? (rd >> 16) : rd;
        r = s ? 32'($signed(sh[15:0])) : {16'h0, sh[15:0]};
      end
      2'd2: begin
        sh = rd >> (8 * int'(a));
        r = s ? 32'($signed(sh[7:0])) : {24'h0, sh[7:0]};
      end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Monitor: every out_valid pulse must match the oldest predicted result.
  always @(negedge clk) begin
    if (resetn && out_valid) begin
      ExpResult e;
      outValidCount++;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid: got data=%h dest=%0d, required no output", out_data, out_dest);
      end else begin
        e = expQ.pop_front();
        if (out_data !== e.data || out_dest !== e.dest) begin
          errors++;
          $display("FAIL result: got data=%h dest=%0d, required data=%h dest=%0d",
                   out_data, out_dest, e.data, e.dest);
        end else begin
          $display("result data=%h dest=%0d ok", out_data, out_dest);
        end
      end
    end
  end

  // One clock of stimulus; the model is advanced with pre-edge state.
  task automatic cycle(input logic pv, input logic [1:0] a, input logic [1:0] sz, input logic s,
                       input logic [4:0] d, input logic rok, input logic [31:0] rd, input logic fl);
    ModelEntry m;
    ExpResult  e;
    bit ready;
    ready = (modelQ.size() < DEPTH);
    req_valid = pv; req_addr_lo = a; req_size = sz; req_sign = s; req_dest = d;
    rdata_ok = rok; rdata = rd; flush = fl;
    if (rok && modelQ.size() != 0) begin
      m = modelQ.pop_front();
      if (!m.discard && !fl) begin
        e.data = refExt(rd, m.addrLo, m.size, m.sign);
        e.dest = m.dest;
        expQ.push_back(e);
      end
    end
    if (fl) foreach (modelQ[i]) modelQ[i].discard = 1'b1;
    if (pv && ready) begin
      m.addrLo = a; m.size = sz; m.sign = s; m.dest = d; m.discard = fl;
      modelQ.push_back(m);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; rdata_ok = 1'b0; flush = 1'b0;
  endtask

  task automatic push(input logic [1:0] a, input logic [1:0] sz, input logic s, input logic [4:0] d);
    cycle(1'b1, a, sz, s, d, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic resp(input logic [31:0] rd);
    cycle(1'b0, 2'd0, 2'd0, 1'b0, 5'd0, 1'b1, rd, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    req_valid = 1'b0; req_addr_lo = '0; req_size = '0; req_sign = 1'b0; req_dest = '0;
    rdata_ok = 1'b0; rdata = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_dest !== 5'h0 || pending_cnt !== '0
        || req_ready !== 1'b1 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%h dst=%0d cnt=%0d rdy=%b perr=%b, required 0/0/0/0/1/0",
               out_valid, out_data, out_dest, pending_cnt, req_ready, proto_err);
    end else $display("reset state ok");
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_lb();
    push(2'b11, 2'b10, 1'b1, 5'd5);
    idle();
    resp(32'h80FF_0000);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FF80 || out_dest !== 5'd5) begin
      errors++;
      $display("FAIL single_lb: got v=%b d=%h dst=%0d, required 1 ffffff80 5", out_valid, out_data, out_dest);
    end else $display("single lb ok");
    idle();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL lb_pulse_hold: got v=%b d=%h, required 0 ffffff80", out_valid, out_data);
    end else $display("lb pulse/hold ok");
  endtask

  task automatic test_half();
    logic [1:0]  addrs [3] = '{2'b10, 2'b10, 2'b00};
    logic        signs [3] = '{1'b0, 1'b1, 1'b1};
    logic [31:0] exps  [3] = '{32'h0000_8001, 32'hFFFF_8001, 32'h0000_7FFF};
    for (int i = 0; i < 3; i++) begin
      push(addrs[i], 2'b01, signs[i], 5'(10 + i));
      idle();
      resp(32'h8001_7FFF);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exps[i] || out_dest !== 5'(10 + i)) begin
        errors++;
        $display("FAIL half_%0d: got v=%b d=%h dst=%0d, required 1 %h %0d",
                 i, out_valid, out_data, out_dest, exps[i], 10 + i);
      end else $display("half %0d ok", i);
    end
  endtask

  task automatic test_full_order();
    push(2'b00, 2'b00, 1'b0, 5'd1);
    push(2'b00, 2'b00, 1'b0, 5'd2);
    checks++;
    if (req_ready !== 1'b0 || pending_cnt !== 2) begin
      errors++;
      $display("FAIL full: got rdy=%b cnt=%0d, required 0 2", req_ready, pending_cnt);
    end else $display("full ok");
    push(2'b00, 2'b00, 1'b0, 5'd3);
    checks++;
    if (pending_cnt !== 2) begin
      errors++;
      $display("FAIL push_when_full: got cnt=%0d, required 2", pending_cnt);
    end else $display("push when full ignored ok");
    resp(32'h1111_1111);
    checks++;
    if (out_dest !== 5'd1) begin
      errors++;
      $display("FAIL order_first: got dest=%0d, required 1", out_dest);
    end else $display("order first ok");
    resp(32'h2222_2222);
    checks++;
    if (out_dest !== 5'd2) begin
      errors++;
      $display("FAIL order_second: got dest=%0d, required 2", out_dest);
    end else $display("order second ok");
    push(2'b01, 2'b10, 1'b0, 5'd4);
    cycle(1'b1, 2'b00, 2'b00, 1'b0, 5'd6, 1'b1, 32'h0000_AB00, 1'b0);
    checks++;
    if (pending_cnt !== 1 || out_data !== 32'h0000_00AB) begin
      errors++;
      $display("FAIL push_pop_same: got cnt=%0d d=%h, required 1 000000ab", pending_cnt, out_data);
    end else $display("push+pop same cycle ok");
    resp(32'hCAFE_BABE);
    idle();
    checks++;
    if (pending_cnt !== 0 || expQ.size() != 0) begin
      errors++;
      $display("FAIL drain_full: got cnt=%0d outstanding=%0d, required 0 0", pending_cnt, expQ.size());
    end else $display("drain ok");
  endtask

  task automatic test_flush();
    int v0;
    v0 = outValidCount;
    push(2'b00, 2'b00, 1'b0, 5'd7);
    push(2'b00, 2'b00, 1'b0, 5'd8);
    cycle(1'b0, 2'd0, 2'd0, 1'b0, 5'd0, 1'b1, 32'h7777_7777, 1'b1);
    push(2'b00, 2'b10, 1'b1, 5'd9);
    resp(32'h8888_8888);
    resp(32'h0000_00F0);
    idle();
    checks++;
    if (outValidCount - v0 != 1 || out_dest !== 5'd9 || out_data !== 32'hFFFF_FFF0 || pending_cnt !== 0) begin
      errors++;
      $display("FAIL flush: got pulses=%0d dst=%0d d=%h cnt=%0d, required 1 9 fffffff0 0",
               outValidCount - v0, out_dest, out_data, pending_cnt);
    end else $display("flush ok");
  endtask

  task automatic test_proto_err();
    cycle(1'b1, 2'b00, 2'b01, 1'b1, 5'd20, 1'b1, 32'h1234_5678, 1'b0);
    checks++;
    if (proto_err !== 1'b1 || pending_cnt !== 1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL proto_set: got perr=%b cnt=%0d v=%b, required 1 1 0", proto_err, pending_cnt, out_valid);
    end else $display("proto_err set ok");
    idle();
    resp(32'h0000_8000);
    checks++;
    if (out_data !== 32'hFFFF_8000 || out_dest !== 5'd20) begin
      errors++;
      $display("FAIL proto_after: got d=%h dst=%0d, required ffff8000 20", out_data, out_dest);
    end else $display("load after proto_err ok");
    idle();
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL proto_sticky: got perr=%b, required 1", proto_err);
    end else $display("proto_err sticky ok");
  endtask

  task automatic test_async_reset();
    push(2'b00, 2'b00, 1'b0, 5'd10);
    push(2'b00, 2'b00, 1'b0, 5'd11);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (pending_cnt !== 0 || out_valid !== 1'b0 || req_ready !== 1'b1 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got cnt=%0d v=%b rdy=%b perr=%b, required 0 0 1 0",
               pending_cnt, out_valid, req_ready, proto_err);
    end else $display("async reset ok");
    modelQ.delete();
    expQ.delete();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    push(2'b10, 2'b10, 1'b0, 5'd12);
    resp(32'h00C3_0000);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000_00C3 || out_dest !== 5'd12) begin
      errors++;
      $display("FAIL post_reset_load: got v=%b d=%h dst=%0d, required 1 000000c3 12",
               out_valid, out_data, out_dest);
    end else $display("post-reset load ok");
    idle();
  endtask

  initial begin
    test_reset();
    test_single_lb();
    test_half();
    test_full_order();
    test_flush();
    test_proto_err();
    test_async_reset();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL missing_results: got %0d undelivered, required 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_load_align.md
Name: dcache_load_align

Overview:
- Load-return side of the data-cache interface, paired with the store byte-enable logic in EXE.
- Records each issued load's size, sign, address low bits and destination register in a small in-order tracking FIFO.
- When the cache returns data, pops the oldest entry, extracts the addressed byte/halfword, sign- or zero-extends it, and presents a registered writeback result.
- Sits between DCache response and MEM/WB; handles flush of in-flight loads without losing response ordering.

Parameters:
- DEPTH, 2, number of outstanding loads tracked; power of 2, ≥2.
- PTR_W, $clog2(DEPTH), FIFO pointer width; derived, not overridden.

Ports:
- clk  in  1  core clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  load issued to DCache this cycle; meaningful only when req_ready=1.
- req_ready  out  1  tracking FIFO not full.
- req_addr_lo  in  2  EXE_ALUOut[1:0] of the load.
- req_size  in  2  LoadType size: 00 word, 01 half, 10 byte.
- req_sign  in  1  1 = sign-extend (LB/LH), 0 = zero-extend (LBU/LHU).
- req_dest  in  5  destination GPR index.
- rdata_ok  in  1  DCache returns load data this cycle.
- rdata  in  32  raw aligned word from DCache.
- flush  in  1  pipeline flush; all in-flight loads become discard.
- out_valid  out  1  registered result valid, one-cycle pulse per load.
- out_data  out  32  extended load result.
- out_dest  out  5  destination GPR of out_data.
- pending_cnt  out  PTR_W+1  entries currently in FIFO.
- proto_err  out  1  sticky: rdata_ok seen with FIFO empty.

Behaviour:
- Reset (async, resetn=0):
  - pointers, count, proto_err, out_valid cleared to 0.
  - out_data = 32'h0, out_dest = 5'h0.
  - Entries' discard bits cleared; entry payload need not be reset.
  - Reset mid-operation drops all in-flight entries.
- Push: req_valid && req_ready writes {addr_lo, size, sign, dest, discard=flush} at wptr; wptr wraps modulo DEPTH.
- req_ready = (count != DEPTH); no same-cycle pop bypass when full.
- Pop: rdata_ok && count != 0 reads the entry at rptr; rptr wraps modulo DEPTH.
- Push and pop in the same cycle: count unchanged; legal at any occupancy below full.
- rdata_ok with count == 0: no pop, no output, proto_err set until reset. This holds even if req_valid is asserted the same cycle (cache latency ≥1).
- Extraction, from the popped entry:
  - size 00: result = rdata; addr_lo ignored (misaligned loads are excepted upstream and never issued).
  - size 01: half = addr_lo[1] ? rdata[31:16] : rdata[15:0]; upper 16 bits = sign ? half[15] : 0.
  - size 10: byte = rdata[8*addr_lo +: 8]; upper 24 bits = sign ? byte[7] : 0.
  - size 11: result = 32'h0 (reserved).
- Output timing: out_valid=1 exactly one cycle after the pop, only if the entry's discard=0. out_data/out_dest update on that pop. out_valid=0 otherwise; out_data/out_dest hold their last value.
- Flush:
  - Sets discard on every valid entry.
  - A same-cycle push is also written with discard=1.
  - Responses for discarded entries are still consumed in order but produce no out_valid.
  - A pop in the flush cycle is itself discarded.
  - Flush does not move pointers.
- pending_cnt = count; reflects the post-reset value immediately.

Decomposition:
- Shared package (CPU_Defines): LoadType struct (ReadMem, size, sign); size encodings LOADTYPE_LW=2'b00, LOADTYPE_LH=2'b01, LOADTYPE_LB=2'b10.
- One sub-module: load_ext, purely combinational {rdata, addr_lo, size, sign} -> 32-bit result. It is reused by uncached-load paths.
- The FIFO stays inline.

Test Plan:
- Single LB: push addr_lo=2'b11, size=10, sign=1, dest=5; 2 cycles later rdata_ok, rdata=32'h80FF_0000 -> next cycle out_valid=1, out_data=32'hFFFF_FF80, out_dest=5.
- LHU/LH: addr_lo=2'b10, rdata=32'h8001_7FFF. sign=0 -> 32'h0000_8001; sign=1 -> 32'hFFFF_8001. addr_lo=2'b00, sign=1 -> 32'h0000_7FFF.
- Full/ordering: push dests 1,2 back-to-back -> req_ready=0, pending_cnt=2. A push attempt is ignored. Two responses -> out_dest 1 then 2. Then push+pop in the same cycle keeps pending_cnt=1.
- Flush: two loads in flight, flush pulses, new load dest=9 pushed the next cycle. Three responses -> only one out_valid, with out_dest=9; pending_cnt returns to 0.
- Protocol error: rdata_ok with FIFO empty -> proto_err=1 and stays 1, no out_valid, pointers unchanged. Cleared only by resetn=0.
- Async reset mid-flight: resetn low between clock edges with pending_cnt=2 -> pending_cnt=0, out_valid=0, req_ready=1 immediately, without waiting for a clock edge.
